// File: rtl/qspi_flash_sequencer_pkg.sv
// Shared command encodings, failure codes, state types and the page data pattern
// for the QSPI flash programming sequencer.
package qspi_flash_sequencer_pkg;

    localparam logic [7:0] CMD_RDID   = 8'h9F;
    localparam logic [7:0] CMD_WRVECR = 8'h61;
    localparam logic [7:0] CMD_WREN   = 8'h06;
    localparam logic [7:0] CMD_PP     = 8'h02;
    localparam logic [7:0] CMD_RDSR   = 8'h05;
    localparam logic [7:0] CMD_SSE    = 8'h20;
    localparam logic [7:0] CMD_READ   = 8'h03;

    localparam logic [7:0] JEDEC_ID   = 8'h20;
    // Volatile enhanced config value written to switch the part into quad I/O.
    localparam logic [7:0] VECR_QUAD  = 8'b010_01_111;

    localparam logic [2:0] FAIL_NONE   = 3'd0;
    localparam logic [2:0] FAIL_ID     = 3'd1;
    localparam logic [2:0] FAIL_CTRL   = 3'd2;
    localparam logic [2:0] FAIL_POLL   = 3'd3;
    localparam logic [2:0] FAIL_VERIFY = 3'd4;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RDID,
        S_WRVECR,
        S_PAGE,
        S_WREN_E,
        S_SSE,
        S_POLL_E,
        S_WREN_P,
        S_PP,
        S_POLL_P,
        S_VERIFY,
        S_DONE,
        S_FAIL
    } seq_state_t;

    typedef enum logic [1:0] {
        CI_IDLE,
        CI_TRIG,
        CI_GAP,
        CI_WAIT
    } ci_state_t;

    // Byte i of page p is seed + p + i (mod 256); byte 0 sits in bits [7:0].
    function automatic logic [2047:0] page_pattern(input logic [7:0] seed,
                                                   input logic [7:0] page);
        logic [2047:0] d;
        d = '0;
        for (int i = 0; i < 256; i++) begin
            d[i*8 +: 8] = seed + page + 8'(i);
        end
        return d;
    endfunction

endpackage

// File: rtl/qspi_cmd_issue.sv
// One controller transaction: a single-cycle trigger, a dead cycle while the
// controller raises busy, then ack on the first idle cycle with its error flag.
module qspi_cmd_issue
    import qspi_flash_sequencer_pkg::*;
(
    input  logic clk,
    input  logic RESET,
    input  logic req,
    input  logic mc_busy,
    input  logic mc_error,
    output logic trigger,
    output logic ack,
    output logic err
);

    ci_state_t state, nxt;

    always_ff @(posedge clk) begin
        if (RESET) state <= CI_IDLE;
        else       state <= nxt;
    end

    always_comb begin
        nxt     = state;
        trigger = 1'b0;
        ack     = 1'b0;
        case (state)
            CI_IDLE: if (req) nxt = CI_TRIG;
            CI_TRIG: begin
                trigger = 1'b1;
                nxt     = CI_GAP;
            end
            // busy is not trusted until the controller has seen the trigger
            CI_GAP:  nxt = CI_WAIT;
            CI_WAIT: if (!mc_busy) begin
                ack = 1'b1;
                nxt = CI_IDLE;
            end
            default: nxt = CI_IDLE;
        endcase
    end

    assign err = ack & mc_error;

endmodule

// File: rtl/qspi_flash_sequencer.sv
// Drives qspi_mem_controller through ID check, quad enable, subsector erase,
// page program with WIP polling and read-back verify for a run of pages.
module qspi_flash_sequencer
    import qspi_flash_sequencer_pkg::*;
#(
    parameter  int MAX_PAGES   = 16,
    parameter  int QUAD_EN     = 1,
    parameter  int ERASE_EN    = 1,
    parameter  int POLL_LIMIT  = 4_000_000,
    parameter  int STARTUP_DLY = 10_000,
    localparam int W           = $clog2(MAX_PAGES + 1)
) (
    input  logic          clk,
    input  logic          RESET,
    input  logic          start,
    input  logic [23:0]   base_addr,
    input  logic [W-1:0]  num_pages,
    input  logic [7:0]    seed,
    output logic          mc_trigger,
    output logic          mc_quad,
    output logic [7:0]    mc_cmd,
    output logic [23:0]   mc_addr,
    output logic [2047:0] mc_data,
    input  logic [7:0]    mc_readout,
    input  logic          mc_busy,
    input  logic          mc_error,
    output logic          seq_busy,
    output logic          done,
    output logic          fail,
    output logic [2:0]    fail_code,
    output logic [W-1:0]  pages_done
);

    localparam int SW = $clog2(STARTUP_DLY + 2);
    localparam int PW = $clog2(POLL_LIMIT + 1);

    seq_state_t     state, nxt;
    logic [SW-1:0]  startup_cnt;
    logic           startup_ok;
    logic [W-1:0]   num_q, num_in;
    logic [7:0]     seed_q;
    logic [23:0]    cur_addr;
    logic [PW-1:0]  poll_cnt;
    logic           poll_hit;
    logic           quad_q;
    logic           erase_now, last_page;

    logic           req, cmd_ack, cmd_err;
    logic           accept, set_fail, quad_set, page_ok, poll_inc;
    logic [2:0]     fcode;

    qspi_cmd_issue u_issue (
        .clk      (clk),
        .RESET    (RESET),
        .req      (req),
        .mc_busy  (mc_busy),
        .mc_error (mc_error),
        .trigger  (mc_trigger),
        .ack      (cmd_ack),
        .err      (cmd_err)
    );

    assign startup_ok = (startup_cnt == SW'(STARTUP_DLY));
    assign num_in     = (num_pages > W'(MAX_PAGES)) ? W'(MAX_PAGES) : num_pages;
    assign poll_hit   = (poll_cnt >= PW'(POLL_LIMIT - 1));
    // Erase at every 4 KiB boundary, and always ahead of the first page of a run.
    assign erase_now  = (ERASE_EN != 0) && ((cur_addr[11:0] == 12'h000) || (pages_done == '0));
    assign last_page  = ((pages_done + 1'b1) == num_q);

    assign seq_busy   = !(state == S_IDLE || state == S_FAIL || state == S_DONE);
    assign done       = (state == S_DONE);
    assign fail       = (state == S_FAIL);
    assign mc_quad    = quad_q;

    always_ff @(posedge clk) begin
        if (RESET) state <= S_IDLE;
        else       state <= nxt;
    end

    always_comb begin
        nxt      = state;
        accept   = 1'b0;
        set_fail = 1'b0;
        fcode    = FAIL_NONE;
        quad_set = 1'b0;
        page_ok  = 1'b0;
        poll_inc = 1'b0;
        req      = 1'b0;
        mc_cmd   = 8'h00;
        mc_addr  = 24'h0;
        mc_data  = '0;
        case (state)
            S_IDLE, S_FAIL: begin
                if (start && startup_ok) begin
                    accept = 1'b1;
                    nxt    = (num_in == '0) ? S_DONE : S_RDID;
                end
            end
            S_RDID: begin
                req    = 1'b1;
                mc_cmd = CMD_RDID;
                if (cmd_ack) begin
                    if (mc_readout != JEDEC_ID) begin
                        nxt      = S_FAIL;
                        set_fail = 1'b1;
                        fcode    = FAIL_ID;
                    end else begin
                        nxt = (QUAD_EN != 0) ? S_WRVECR : S_PAGE;
                    end
                end
            end
            S_WRVECR: begin
                req          = 1'b1;
                mc_cmd       = CMD_WRVECR;
                mc_data[7:0] = VECR_QUAD;
                if (cmd_ack) begin
                    quad_set = 1'b1;
                    nxt      = S_PAGE;
                end
            end
            S_PAGE: nxt = erase_now ? S_WREN_E : S_WREN_P;
            S_WREN_E: begin
                req    = 1'b1;
                mc_cmd = CMD_WREN;
                if (cmd_ack) nxt = S_SSE;
            end
            S_SSE: begin
                req     = 1'b1;
                mc_cmd  = CMD_SSE;
                mc_addr = cur_addr;
                if (cmd_ack) nxt = S_POLL_E;
            end
            S_POLL_E, S_POLL_P: begin
                req    = 1'b1;
                mc_cmd = CMD_RDSR;
                if (cmd_ack) begin
                    if (!mc_readout[0]) begin
                        nxt = (state == S_POLL_E) ? S_WREN_P : S_VERIFY;
                    end else if (poll_hit) begin
                        nxt      = S_FAIL;
                        set_fail = 1'b1;
                        fcode    = FAIL_POLL;
                    end else begin
                        poll_inc = 1'b1;
                    end
                end
            end
            S_WREN_P: begin
                req    = 1'b1;
                mc_cmd = CMD_WREN;
                if (cmd_ack) nxt = S_PP;
            end
            S_PP: begin
                req     = 1'b1;
                mc_cmd  = CMD_PP;
                mc_addr = cur_addr;
                mc_data = page_pattern(seed_q, 8'(pages_done));
                if (cmd_ack) nxt = S_POLL_P;
            end
            S_VERIFY: begin
                req     = 1'b1;
                mc_cmd  = CMD_READ;
                mc_addr = cur_addr;
                if (cmd_ack) begin
                    if (mc_readout != (seed_q + 8'(pages_done))) begin
                        nxt      = S_FAIL;
                        set_fail = 1'b1;
                        fcode    = FAIL_VERIFY;
                    end else begin
                        page_ok = 1'b1;
                        nxt     = last_page ? S_DONE : S_PAGE;
                    end
                end
            end
            S_DONE:  nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
        // A controller error on any transaction outranks the response contents.
        if (cmd_err) begin
            nxt      = S_FAIL;
            set_fail = 1'b1;
            fcode    = FAIL_CTRL;
            quad_set = 1'b0;
            page_ok  = 1'b0;
            poll_inc = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            startup_cnt <= '0;
            num_q       <= '0;
            seed_q      <= 8'h00;
            cur_addr    <= 24'h0;
            pages_done  <= '0;
            fail_code   <= FAIL_NONE;
            quad_q      <= 1'b0;
            poll_cnt    <= '0;
        end else begin
            if (!startup_ok) startup_cnt <= startup_cnt + 1'b1;
            if (accept) begin
                num_q      <= num_in;
                seed_q     <= seed;
                cur_addr   <= {base_addr[23:8], 8'h00};
                pages_done <= '0;
                fail_code  <= FAIL_NONE;
            end
            if (set_fail) fail_code <= fcode;
            if (quad_set) quad_q <= 1'b1;
            if (page_ok) begin
                pages_done <= pages_done + 1'b1;
                cur_addr   <= cur_addr + 24'd256;
            end
            if (poll_inc)
                poll_cnt <= poll_cnt + 1'b1;
            else if (state != S_POLL_E && state != S_POLL_P)
                poll_cnt <= '0;
        end
    end

endmodule
